dec3to8_case: RTL and testbench

DEC3TO8_CASE -- requirements
Module: dec3to8_case

---
 rtl/dec3to8_case.sv | 82 ++++++++
 tb/tb_dec3to8_case.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/dec3to8_case.sv
// dec3to8_case: registered 3-to-8 one-hot decoder with enable and a polarity parameter.
// Optional hold behaviour is selected with the DEC3TO8_HOLD_EN macro.
// - Undefined (default): en == 0 clears the output to all-inactive.
// - Defined: en == 0 keeps the last decoded value.
// State is kept active-high internally. Polarity is applied after the register,
// so the reset value also follows ACTIVE_LOW.
module dec3to8_case #(
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [2:0] in,
   output logic [7:0] out
);

   logic [7:0] code_dec;  // decode of in alone
   logic [7:0] dec;       // en-gated decode
   logic [7:0] dec_d;
   logic [7:0] dec_q;

   // Explicit decode of every code.
   // Anything not matching a legal code (X/Z) falls to all-zero.
   always_comb begin
      code_dec = 8'h00;
      case (in)
         3'd0:    code_dec = 8'h01;
         3'd1:    code_dec = 8'h02;
         3'd2:    code_dec = 8'h04;
         3'd3:    code_dec = 8'h08;
         3'd4:    code_dec = 8'h10;
         3'd5:    code_dec = 8'h20;
         3'd6:    code_dec = 8'h40;
         3'd7:    code_dec = 8'h80;
         default: code_dec = 8'h00;
      endcase
   end

   // Gate with en. An unresolved en selects nothing.
   always_comb begin
      dec = 8'h00;
      case (en)
         1'b1:    dec = code_dec;
         default: dec = 8'h00;
      endcase
   end

`ifdef DEC3TO8_HOLD_EN
   // en == 0 holds the previous value; an unresolved en still clears.
   always_comb begin
      dec_d = dec;
      case (en)
         1'b0:    dec_d = dec_q;
         default: dec_d = dec;
      endcase
   end
`else
   // en == 0 clears to all-inactive through the gated decode.
   always_comb begin
      dec_d = dec;
   end
`endif

   // Output register with asynchronous clear.
   // Reset also discards any held value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dec_q <= 8'h00;
      else        dec_q <= dec_d;
   end

   assign out = ACTIVE_LOW ? ~dec_q : dec_q;

   // At most one line is ever selected.
   a_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(dec_q));

`ifndef DEC3TO8_HOLD_EN
   // Without hold, a disabled cycle always produces all-inactive on the next edge.
   a_dis_clear : assert property (@(posedge clk) disable iff (!rst_n)
                                  (en == 1'b0) |=> (dec_q == 8'h00));
`endif

endmodule

// File: tb/tb_dec3to8_case.sv
// tb_dec3to8_case: scoreboard bench for dec3to8_case.
// Drives both polarities side by side from the same en/in.
// The driver pushes the expected active-high value per cycle.
// The monitor pops one entry per rising edge and checks both instances.
module tb_dec3to8_case;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [2:0] in;
   logic [7:0] out_hi;
   logic [7:0] out_lo;

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] expq [$];

   always #5 clk = ~clk;

   dec3to8_case #(.ACTIVE_LOW(1'b0)) u_hi (.clk(clk), .rst_n(rst_n), .en(en), .in(in), .out(out_hi));
   dec3to8_case #(.ACTIVE_LOW(1'b1)) u_lo (.clk(clk), .rst_n(rst_n), .en(en), .in(in), .out(out_lo));

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Called on a negedge.
   // Sets inputs for the next rising edge, queues the expected result, then waits for the next negedge.
   task automatic step(input logic e, input logic [2:0] c, input logic [7:0] exp);
      en = e;
      in = c;
      expq.push_back(exp);
      @(negedge clk);
   endtask

   // Asynchronous reset pulse between edges, with immediate checks while low.
   task automatic reset_pulse(input logic [7:0] pre);
      #1;
      check("pre_reset_hi", out_hi, pre);
      check("pre_reset_lo", out_lo, ~pre);
      rst_n = 1'b0;
      #1;
      check("async_reset_hi", out_hi, 8'h00);
      check("async_reset_lo", out_lo, 8'hFF);
      #1;
      rst_n = 1'b1;
   endtask

   // Monitor: one scoreboard entry per rising edge once stimulus is queued.
   initial begin
      logic [7:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            check("out_active_high", out_hi, e);
            check("out_active_low", out_lo, ~e);
         end
      end
   end

   // Watchdog.
   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // Driver.
   initial begin
      logic [7:0] sweep_exp [8];
      logic [7:0] hold_exp;
      sweep_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

      rst_n = 1'b0;
      en    = 1'b1;
      in    = 3'd5;
      #1;
      check("reset_immediate_hi", out_hi, 8'h00);
      check("reset_immediate_lo", out_lo, 8'hFF);

      // Edges during reset keep the output cleared.
      for (int i = 0; i < 3; i++) begin
         expq.push_back(8'h00);
         @(negedge clk);
      end

      // Release reset; the first edge loads the sweep's first code.
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) step(1'b1, 3'(i), sweep_exp[i]);

`ifdef DEC3TO8_HOLD_EN
      hold_exp = 8'h08;
`else
      hold_exp = 8'h00;
`endif
      // Disable: en fall and in change on the same edge.
      step(1'b1, 3'd3, 8'h08);
      step(1'b0, 3'd6, hold_exp);
      step(1'b0, 3'd2, hold_exp);
      step(1'b1, 3'd6, 8'h40);

      // Mid-run reset between edges, then en = 1, in = 1.
      en = 1'b1;
      in = 3'd1;
      expq.push_back(8'h02);
      reset_pulse(8'h40);
      @(negedge clk);

      // After reset with en low, the held value is the reset value.
      en = 1'b0;
      in = 3'd7;
      expq.push_back(8'h00);
      reset_pulse(8'h02);
      @(negedge clk);
      step(1'b0, 3'd4, 8'h00);

      // Unresolved select decodes to nothing on a 4-state simulator.
      // Otherwise use a legal code.
      en = 1'b1;
      in = 3'bx1x;
      if ($isunknown(in)) begin
         step(1'b1, 3'bx1x, 8'h00);
      end else begin
         step(1'b1, 3'b010, 8'h04);
      end

      step(1'b1, 3'd7, 8'h80);
      step(1'b1, 3'd0, 8'h01);
      step(1'b0, 3'd0, hold_exp == 8'h00 ? 8'h00 : 8'h01);

      // Drain the scoreboard within a bounded number of edges.
      for (int i = 0; i < 5 && expq.size() > 0; i++) @(negedge clk);
      n_chk++;
      if (expq.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d entries left expected 0", expq.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
